// File: rtl/tib_loader.sv
// Host byte stream -> terminal input buffer line editor for the eJ32 outer interpreter.
// Edits one line into SPRAM, runs the core on it, and re-clamps the core when it is done.
module tib_loader #(
    parameter int unsigned ASZ    = 17,
    parameter int unsigned TIB    = 'h1000,
    parameter int unsigned TIB_SZ = 'h100,
    localparam int unsigned IW    = $clog2(TIB_SZ)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx_valid,
    input  logic [7:0]     rx_data,
    output logic           rx_ready,
    output logic           mem_sel,
    output logic           mem_we,
    output logic [ASZ-1:0] mem_addr,
    output logic [7:0]     mem_wdata,
    output logic           core_clr,
    input  logic           core_done,
    output logic [IW-1:0]  line_len,
    output logic           overflow
);

    localparam logic [IW-1:0]  IdxMax  = IW'(TIB_SZ - 1);
    localparam logic [ASZ-1:0] TibBase = ASZ'(TIB);

    localparam logic [7:0] ChBs = 8'h08;
    localparam logic [7:0] ChLf = 8'h0A;
    localparam logic [7:0] ChCr = 8'h0D;

    typedef enum logic [1:0] {StLoad, StTerm, StRun} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            we_q, we_d;
    logic [ASZ-1:0]  addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            sel_q, sel_d;
    logic            clr_q, clr_d;
    logic [IW-1:0]   len_q, len_d;
    logic            ovf_q, ovf_d;
    logic            accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StLoad;
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= TibBase;
            wdata_q <= 8'h00;
            sel_q   <= 1'b1;
            clr_q   <= 1'b1;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            clr_q   <= clr_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    assign rx_ready = (state_q == StLoad) & ~rst;
    assign accept   = rx_valid & rx_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        clr_d   = clr_q;
        len_d   = len_q;
        ovf_d   = ovf_q;

        case (state_q)
            StLoad: begin
                if (accept) begin
                    case (rx_data)
                        ChCr: begin
                        end
                        ChBs: begin
                            if (idx_q != '0) begin
                                idx_d = idx_q - IW'(1);
                            end
                        end
                        ChLf: begin
                            // Terminator write is issued from the registered strobe during TERM.
                            we_d    = 1'b1;
                            addr_d  = TibBase + ASZ'(idx_q);
                            wdata_d = 8'h00;
                            state_d = StTerm;
                        end
                        default: begin
                            if (idx_q != IdxMax) begin
                                we_d    = 1'b1;
                                addr_d  = TibBase + ASZ'(idx_q);
                                wdata_d = rx_data;
                                idx_d   = idx_q + IW'(1);
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            StTerm: begin
                len_d   = idx_q;
                sel_d   = 1'b0;
                clr_d   = 1'b0;
                state_d = StRun;
            end
            StRun: begin
                if (core_done) begin
                    clr_d   = 1'b1;
                    sel_d   = 1'b1;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = StLoad;
                end
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    assign mem_sel   = sel_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign core_clr  = clr_q;
    assign line_len  = len_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_tib_loader.sv
// Directed bench for tib_loader: drives host lines, models the SPRAM write port, checks results.
module tb_tib_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_sel;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        core_clr;
    logic        core_done;
    logic [7:0]  line_len;
    logic        overflow;

    int nvec  = 0;
    int nfail = 0;

    logic [7:0] mem [0:131071];
    int wr_count = 0;
    int hit_1100 = 0;
    int bad_we   = 0;

    tib_loader dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .mem_sel   (mem_sel),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_clr  (core_clr),
        .core_done (core_done),
        .line_len  (line_len),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // SPRAM model: captures whatever the write port presents on each edge.
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_count <= wr_count + 1;
            if (mem_addr == 17'h1100) hit_1100 <= hit_1100 + 1;
            if (!mem_sel) bad_we <= bad_we + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts and ends on a negedge; leaves rx_valid high for back-to-back streaming.
    task automatic send_b(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_b(s[i]);
    endtask

    task automatic pulse_done();
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
    endtask

    int w0;

    initial begin
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        core_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_mem_sel", mem_sel, 1);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 32'h1000);
        chk("rst_core_clr", core_clr, 1);
        chk("rst_line_len", line_len, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("load_rx_ready", rx_ready, 1);

        // core_done outside RUN has no effect
        pulse_done();
        chk("done_in_load_clr", core_clr, 1);
        chk("done_in_load_ready", rx_ready, 1);

        // 1: "2 3 +\n" back-to-back
        w0 = wr_count;
        send_str("2 3 +");
        send_b(8'h0A);
        rx_valid = 1'b0;
        chk("t1_term_we", mem_we, 1);
        chk("t1_term_addr", mem_addr, 32'h1005);
        chk("t1_term_clr", core_clr, 1);
        @(negedge clk);
        chk("t1_run_clr", core_clr, 0);
        chk("t1_run_sel", mem_sel, 0);
        chk("t1_run_we", mem_we, 0);
        chk("t1_line_len", line_len, 5);
        chk("t1_m1000", mem[17'h1000], 32'h32);
        chk("t1_m1001", mem[17'h1001], 32'h20);
        chk("t1_m1002", mem[17'h1002], 32'h33);
        chk("t1_m1003", mem[17'h1003], 32'h20);
        chk("t1_m1004", mem[17'h1004], 32'h2B);
        chk("t1_m1005", mem[17'h1005], 32'h00);
        chk("t1_writes", wr_count - w0, 6);
        pulse_done();
        chk("t1_done_clr", core_clr, 1);
        chk("t1_done_sel", mem_sel, 1);

        // 2: "12",BS,"3",CR,LF
        w0 = wr_count;
        send_str("12");
        send_b(8'h08);
        send_b(8'h33);
        send_b(8'h0D);
        send_b(8'h0A);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("t2_line_len", line_len, 2);
        chk("t2_m1000", mem[17'h1000], 32'h31);
        chk("t2_m1001", mem[17'h1001], 32'h33);
        chk("t2_m1002", mem[17'h1002], 32'h00);
        chk("t2_writes", wr_count - w0, 4);
        pulse_done();

        // 3: 300 'A' then LF -> overflow
        w0 = wr_count;
        for (int i = 0; i < 300; i++) send_b(8'h41);
        chk("t3_overflow_load", overflow, 1);
        send_b(8'h0A);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("t3_line_len", line_len, 255);
        chk("t3_m1000", mem[17'h1000], 32'h41);
        chk("t3_m10fe", mem[17'h10FE], 32'h41);
        chk("t3_m10ff", mem[17'h10FF], 32'h00);
        chk("t3_writes", wr_count - w0, 256);
        chk("t3_no_1100", hit_1100, 0);
        chk("t3_overflow_run", overflow, 1);

        // 4: byte held during RUN, accepted after core_done
        rx_data = 8'h5A;
        rx_valid = 1'b1;
        chk("t4_ready_run", rx_ready, 0);
        @(negedge clk);
        chk("t4_we_run", mem_we, 0);
        chk("t4_ready_run2", rx_ready, 0);
        pulse_done();
        chk("t4_clr", core_clr, 1);
        chk("t4_sel", mem_sel, 1);
        chk("t4_overflow", overflow, 0);
        chk("t4_ready", rx_ready, 1);
        @(negedge clk);
        rx_valid = 1'b0;
        chk("t4_held_we", mem_we, 1);
        chk("t4_held_addr", mem_addr, 32'h1000);
        chk("t4_held_data", mem_wdata, 32'h5A);

        // 5: reset mid-line
        send_str("abc");
        rx_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rx_ready", rx_ready, 0);
        chk("t5_mem_sel", mem_sel, 1);
        chk("t5_mem_we", mem_we, 0);
        chk("t5_mem_addr", mem_addr, 32'h1000);
        chk("t5_mem_wdata", mem_wdata, 0);
        chk("t5_core_clr", core_clr, 1);
        chk("t5_line_len", line_len, 0);
        chk("t5_overflow", overflow, 0);
        rst = 1'b0;
        @(negedge clk);
        send_b(8'h78);
        send_b(8'h0A);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("t5_x_m1000", mem[17'h1000], 32'h78);
        chk("t5_x_m1001", mem[17'h1001], 32'h00);
        chk("t5_x_line_len", line_len, 1);
        pulse_done();

        // 6: lone LF
        send_b(8'h0A);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("t6_m1000", mem[17'h1000], 32'h00);
        chk("t6_line_len", line_len, 0);
        chk("t6_run_clr", core_clr, 0);
        pulse_done();
        chk("t6_done_clr", core_clr, 1);
        chk("t6_done_ready", rx_ready, 1);

        chk("no_we_without_sel", bad_we, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
